// File: rtl/regbank_writer_pkg.sv
// Shared defaults and FSM state encoding for the register bank write-port controller.
package regbank_writer_pkg;

    localparam int unsigned ADDR_SIZE_DEF = 5;
    localparam int unsigned WORD_SIZE_DEF = 32;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_e;

endpackage

// File: rtl/regbank_writer_rr_arb2.sv
// Two-requester round-robin arbiter with combinational grants.
// Priority flips only on contested, enabled cycles; reset favours requester A.
module rr_arb2 (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic en_i,
    input  logic req_a_i,
    input  logic req_b_i,
    output logic gnt_a_o,
    output logic gnt_b_o
);

    logic prio_b_q;
    logic prio_b_d;

    always_comb begin
        gnt_a_o  = en_i & req_a_i & (~req_b_i | ~prio_b_q);
        gnt_b_o  = en_i & req_b_i & (~req_a_i | prio_b_q);
        prio_b_d = prio_b_q;
        // The winner of a contest loses priority for the next one.
        if (en_i && req_a_i && req_b_i) begin
            prio_b_d = gnt_a_o;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            prio_b_q <= 1'b0;
        end else begin
            prio_b_q <= prio_b_d;
        end
    end

endmodule

// File: rtl/regbank_writer.sv
// Register bank write-port controller: arbitrates two write sources and runs a bank-wide clear.
// Define REGBANK_ZERO_REG_EN to make entry 0 hardwired zero for source writes.
module regbank_writer
    import regbank_writer_pkg::*;
#(
    parameter int unsigned ADDR_SIZE = ADDR_SIZE_DEF,
    parameter int unsigned WORD_SIZE = WORD_SIZE_DEF
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 a_valid,
    output logic                 a_ready,
    input  logic [ADDR_SIZE-1:0] a_addr,
    input  logic [WORD_SIZE-1:0] a_data,
    input  logic                 b_valid,
    output logic                 b_ready,
    input  logic [ADDR_SIZE-1:0] b_addr,
    input  logic [WORD_SIZE-1:0] b_data,
    input  logic                 clr_start,
    output logic                 clr_busy,
    output logic                 clr_done,
    output logic                 w,
    output logic [ADDR_SIZE-1:0] wad,
    output logic [WORD_SIZE-1:0] wdat
);

    localparam logic [ADDR_SIZE:0] CntOne = {{ADDR_SIZE{1'b0}}, 1'b1};

    // Reset asserts asynchronously, releases synchronously.
    logic [1:0] rst_sync_q;
    logic       rst_int_n;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rst_sync_q <= 2'b00;
        end else begin
            rst_sync_q <= {rst_sync_q[0], 1'b1};
        end
    end

    assign rst_int_n = rst_sync_q[1];

    state_e                 state_q, state_d;
    logic [ADDR_SIZE:0]     cnt_q, cnt_d, cnt_nxt;
    logic                   w_q, w_d;
    logic [ADDR_SIZE-1:0]   wad_q, wad_d;
    logic [WORD_SIZE-1:0]   wdat_q, wdat_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;

    logic                   arb_en;
    logic                   gnt_a;
    logic                   gnt_b;
    logic                   xfer;
    logic [ADDR_SIZE-1:0]   xfer_addr;
    logic [WORD_SIZE-1:0]   xfer_data;
    logic                   xfer_drop;

    // Sources are held off for the final clear-write cycle so readies stay low while busy.
    assign arb_en = rst_int_n & (state_q == IDLE) & ~busy_q;

    rr_arb2 u_arb (
        .clk_i   (clk),
        .rst_ni  (rst_int_n),
        .en_i    (arb_en),
        .req_a_i (a_valid),
        .req_b_i (b_valid),
        .gnt_a_o (gnt_a),
        .gnt_b_o (gnt_b)
    );

    assign a_ready   = gnt_a;
    assign b_ready   = gnt_b;
    assign xfer      = gnt_a | gnt_b;
    assign xfer_addr = gnt_a ? a_addr : b_addr;
    assign xfer_data = gnt_a ? a_data : b_data;

`ifdef REGBANK_ZERO_REG_EN
    assign xfer_drop = (xfer_addr == '0);
`else
    assign xfer_drop = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        cnt_nxt = cnt_q + CntOne;
        w_d     = 1'b0;
        wad_d   = '0;
        wdat_d  = '0;
        busy_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (xfer && !xfer_drop) begin
                    w_d    = 1'b1;
                    wad_d  = xfer_addr;
                    wdat_d = xfer_data;
                end
                if (clr_start) begin
                    state_d = CLEAR;
                    cnt_d   = '0;
                end
            end
            CLEAR: begin
                w_d    = 1'b1;
                wad_d  = cnt_q[ADDR_SIZE-1:0];
                busy_d = 1'b1;
                cnt_d  = cnt_nxt;
                // Extra counter bit marks the write to the last entry.
                if (cnt_nxt[ADDR_SIZE]) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
        done_d = busy_q & ~busy_d;
    end

    always_ff @(posedge clk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            w_q     <= 1'b0;
            wad_q   <= '0;
            wdat_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            w_q     <= w_d;
            wad_q   <= wad_d;
            wdat_q  <= wdat_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign w        = w_q;
    assign wad      = wad_q;
    assign wdat     = wdat_q;
    assign clr_busy = busy_q;
    assign clr_done = done_q;

endmodule

// File: tb/tb_regbank_writer.sv
// Scoreboard bench for regbank_writer: stimulus pushes expected writes, a monitor pops on w.
module tb_regbank_writer;

    localparam int AW = 5;
    localparam int DW = 32;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } exp_t;

    logic          clk = 1'b0;
    logic          reset_n = 1'b1;
    logic          a_valid = 1'b0;
    logic          a_ready;
    logic [AW-1:0] a_addr = '0;
    logic [DW-1:0] a_data = '0;
    logic          b_valid = 1'b0;
    logic          b_ready;
    logic [AW-1:0] b_addr = '0;
    logic [DW-1:0] b_data = '0;
    logic          clr_start = 1'b0;
    logic          clr_busy;
    logic          clr_done;
    logic          w;
    logic [AW-1:0] wad;
    logic [DW-1:0] wdat;

    exp_t sb_q[$];
    int   total = 0;
    int   bad = 0;
    int   done_cnt = 0;

    always #5 clk = ~clk;

    regbank_writer #(
        .ADDR_SIZE (AW),
        .WORD_SIZE (DW)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .a_valid   (a_valid),
        .a_ready   (a_ready),
        .a_addr    (a_addr),
        .a_data    (a_data),
        .b_valid   (b_valid),
        .b_ready   (b_ready),
        .b_addr    (b_addr),
        .b_data    (b_data),
        .clr_start (clr_start),
        .clr_busy  (clr_busy),
        .clr_done  (clr_done),
        .w         (w),
        .wad       (wad),
        .wdat      (wdat)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push(input logic [AW-1:0] addr, input logic [DW-1:0] data);
        exp_t e;
        e.addr = addr;
        e.data = data;
        sb_q.push_back(e);
    endtask

    // Monitor: every write the DUT presents must match the head of the scoreboard.
    always @(negedge clk) begin
        if (clr_done === 1'b1) done_cnt++;
        if (w === 1'b1) begin
            if (sb_q.size() == 0) begin
                chk("unexpected_write", {32'd0, wad, 27'd0}, 64'hFFFF_FFFF_FFFF_FFFF);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                chk("write_addr", 64'(wad), 64'(e.addr));
                chk("write_data", 64'(wdat), 64'(e.data));
            end
        end else if (w !== 1'b0) begin
            chk("write_strobe_known", 64'(w), 64'd0);
        end
    end

    task automatic run_clear(input bit repulse, input bit abort);
        int busy_n;
        int done0;
        busy_n = 0;
        done0  = done_cnt;
        @(negedge clk);
        clr_start = 1'b1;
        a_valid   = 1'b1;
        a_addr    = 5'd3;
        a_data    = 32'h33;
        #1;
        chk("clr_same_cycle_ready", 64'(a_ready), 64'd1);
        push(5'd3, 32'h33);
        for (int k = 0; k < 32; k++) begin
            if (!abort || k <= 10) push(5'(k), 32'h0);
        end
        for (int t = 1; t <= 36; t++) begin
            @(negedge clk);
            clr_start = repulse && (t == 8);
            if (abort) begin
                a_valid = 1'b0;
            end else begin
                a_valid = (t <= 34);
                a_addr  = 5'd9;
                a_data  = 32'h99;
            end
            #1;
            if (abort && t == 12) begin
                reset_n = 1'b0;
                #1;
                chk("abort_w", 64'(w), 64'd0);
                chk("abort_wad", 64'(wad), 64'd0);
                chk("abort_wdat", 64'(wdat), 64'd0);
                chk("abort_busy", 64'(clr_busy), 64'd0);
                chk("abort_done", 64'(clr_done), 64'd0);
                repeat (2) @(negedge clk);
                reset_n = 1'b1;
                repeat (4) begin
                    @(negedge clk);
                    #1;
                    chk("post_abort_busy", 64'(clr_busy), 64'd0);
                    chk("post_abort_done", 64'(clr_done), 64'd0);
                end
                chk("abort_no_done_pulse", 64'(done_cnt - done0), 64'd0);
                break;
            end
            busy_n += int'(clr_busy);
            if (t == 1) chk("clr_busy_first", 64'(clr_busy), 64'd0);
            if (t <= 33) begin
                chk("clr_a_ready_low", 64'(a_ready), 64'd0);
                chk("clr_b_ready_low", 64'(b_ready), 64'd0);
            end
            if (t == 33) begin
                chk("clr_busy_last", 64'(clr_busy), 64'd1);
                chk("clr_done_early", 64'(clr_done), 64'd0);
            end
            if (t == 34) begin
                chk("clr_done_pulse", 64'(clr_done), 64'd1);
                chk("clr_busy_fall", 64'(clr_busy), 64'd0);
                chk("post_clr_ready", 64'(a_ready), 64'd1);
                push(5'd9, 32'h99);
            end
            if (t == 35) chk("clr_done_one_cycle", 64'(clr_done), 64'd0);
        end
        a_valid   = 1'b0;
        clr_start = 1'b0;
        if (!abort) begin
            chk("clr_busy_cycles", 64'(busy_n), 64'd32);
            chk("clr_done_count", 64'(done_cnt - done0), 64'd1);
        end
    endtask

    initial begin
        int ia;
        int ib;
        #2 reset_n = 1'b0;
        #1;
        chk("rst_w", 64'(w), 64'd0);
        chk("rst_wad", 64'(wad), 64'd0);
        chk("rst_wdat", 64'(wdat), 64'd0);
        chk("rst_busy", 64'(clr_busy), 64'd0);
        chk("rst_done", 64'(clr_done), 64'd0);
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        repeat (4) @(negedge clk);

        // Lone source A write.
        @(negedge clk);
        a_valid = 1'b1;
        a_addr  = 5'd5;
        a_data  = 32'hDEAD_BEEF;
        #1;
        chk("lone_a_ready", 64'(a_ready), 64'd1);
        chk("lone_a_b_ready", 64'(b_ready), 64'd0);
        push(5'd5, 32'hDEAD_BEEF);
        @(negedge clk);
        a_valid = 1'b0;

        // Contested: grants alternate A,B,A,B starting from A.
        ia = 0;
        ib = 0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            a_valid = 1'b1;
            b_valid = 1'b1;
            a_addr  = 5'(1 + 2 * ia);
            a_data  = 32'hA000_0000 + 32'(ia);
            b_addr  = 5'(2 + 2 * ib);
            b_data  = 32'hB000_0000 + 32'(ib);
            #1;
            chk("rr_a_ready", 64'(a_ready), 64'((k % 2) == 0));
            chk("rr_b_ready", 64'(b_ready), 64'((k % 2) == 1));
            if ((k % 2) == 0) begin
                push(a_addr, a_data);
                ia++;
            end else begin
                push(b_addr, b_data);
                ib++;
            end
        end
        @(negedge clk);
        a_valid = 1'b0;
        b_valid = 1'b0;

        // Source B to address 0.
        @(negedge clk);
        b_valid = 1'b1;
        b_addr  = 5'd0;
        b_data  = 32'h1234;
        #1;
        chk("b_zero_ready", 64'(b_ready), 64'd1);
`ifndef REGBANK_ZERO_REG_EN
        push(5'd0, 32'h1234);
`endif
        @(negedge clk);
        b_valid = 1'b0;
        repeat (2) @(negedge clk);

        run_clear(1'b0, 1'b0);
        repeat (2) @(negedge clk);
        run_clear(1'b1, 1'b0);
        repeat (2) @(negedge clk);
        run_clear(1'b0, 1'b1);

        // After an aborted clear the FSM accepts sources again.
        @(negedge clk);
        a_valid = 1'b1;
        a_addr  = 5'd6;
        a_data  = 32'h66;
        #1;
        chk("post_reset_ready", 64'(a_ready), 64'd1);
        push(5'd6, 32'h66);
        @(negedge clk);
        a_valid = 1'b0;

        repeat (4) @(negedge clk);
        #1;
        chk("scoreboard_drained", 64'(sb_q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1);
    end

endmodule

// File: doc/regbank_writer.md
REGBANK_WRITER -- requirements
Module: regbank_writer

Interface
REQ-001 Parameter ADDR_SIZE, default 5, SHALL be the register bank address width; depth is 2**ADDR_SIZE.
REQ-002 Parameter WORD_SIZE, default 32, SHALL be the register bank data width.
REQ-003 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 reset_n  input  1  SHALL be the asynchronous, active-low reset.
REQ-005 a_valid/a_ready  input/output  1/1  SHALL be the source-A (execute writeback) handshake.
REQ-006 a_addr/a_data  input  ADDR_SIZE/WORD_SIZE  SHALL be the source-A write address and data.
REQ-007 b_valid/b_ready  input/output  1/1  SHALL be the source-B (load return) handshake.
REQ-008 b_addr/b_data  input  ADDR_SIZE/WORD_SIZE  SHALL be the source-B write address and data.
REQ-009 clr_start  input  1  SHALL be a one-cycle pulse requesting a bank-wide clear.
REQ-010 clr_busy/clr_done  output  1/1  SHALL be clear-in-progress level and one-cycle clear-complete pulse.
REQ-011 w/wad/wdat  output  1/ADDR_SIZE/WORD_SIZE  SHALL drive the register bank write port.

Function
REQ-012 Transfers SHALL occur on cycles where valid and ready are both high; at most one source transfers per cycle.
REQ-013 FSM SHALL have states IDLE and CLEAR; reset enters IDLE.
REQ-014 In IDLE, a_ready/b_ready SHALL be combinational grant: only the source granted by the arbiter sees ready high.
REQ-015 Arbitration SHALL be round-robin: with both valid, the grant goes to the source not granted in the last contested cycle; a lone valid source is always granted.
REQ-016 A transfer in cycle N SHALL produce w=1, wad=addr, wdat=data registered in cycle N+1; w=0 in cycles with no transfer or clear write.
REQ-017 clr_start in IDLE SHALL move to CLEAR next cycle; clr_start arriving the same cycle as a transfer SHALL let that transfer complete first.
REQ-018 In CLEAR, a_ready=b_ready=0, clr_busy=1, and one write of zero per cycle SHALL be issued to addresses 0 through 2**ADDR_SIZE-1 in ascending order (every entry, including the last).
REQ-019 After the write to address 2**ADDR_SIZE-1, the FSM SHALL return to IDLE and pulse clr_done for exactly one cycle, coincident with clr_busy falling.
REQ-020 clr_start while in CLEAR SHALL be ignored; the clear address counter SHALL NOT restart.
REQ-021 The clear address counter SHALL be ADDR_SIZE+1 bits wide so termination never depends on wrap-around.

Reset
REQ-022 On reset_n low, w, wad, wdat, clr_busy, clr_done SHALL be 0, the state SHALL be IDLE, the counter 0, and round-robin priority SHALL favour source A.
REQ-023 Reset asserted mid-CLEAR SHALL abort the clear with no clr_done pulse; reset deassertion SHALL be synchronised before first use.

Configuration
REQ-024 With REGBANK_ZERO_REG_EN defined, source transfers to address 0 SHALL complete their handshake but SHALL produce w=0 (entry 0 hardwired zero); clear writes are unaffected.
REQ-025 Without REGBANK_ZERO_REG_EN, address 0 SHALL be written like any other address.

Structure
REQ-026 A shared package SHALL hold ADDR_SIZE/WORD_SIZE defaults and the FSM state enum (IDLE, CLEAR).
REQ-027 The two-requester round-robin arbiter SHALL be a sub-module named rr_arb2.

Verification
REQ-028 a_valid=1, a_addr=5, a_data=0xDEADBEEF alone -> a_ready=1 same cycle; next cycle w=1, wad=5, wdat=0xDEADBEEF.
REQ-029 a and b valid for 4 cycles, first contest -> grants A,B,A,B; four write cycles each one cycle after its grant.
REQ-030 clr_start pulse with ADDR_SIZE=5 -> clr_busy high 32 cycles, wad 0..31 with wdat=0, clr_done pulse on final-exit cycle, readies low throughout.
REQ-031 b_valid=1, b_addr=0, data 0x1234: with REGBANK_ZERO_REG_EN -> b_ready=1, w stays 0; without -> w=1, wad=0, wdat=0x1234.
REQ-032 reset_n low at clear address 10 -> outputs 0 immediately; after release, FSM in IDLE, no clr_done.
REQ-033 clr_start re-pulsed at clear address 7 -> sequence continues 8..31 unchanged, single clr_done.
